// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State encoding, requester IDs and the default bus timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Latches the winner, holds it on the bus until ack or timeout, pulses Rdy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iF_Req,
    input  logic [31:0] iF_Addr,
    output logic        oF_Rdy,
    output logic [31:0] oF_RData,
    input  logic        iD_Req,
    input  logic        iD_Write,
    input  logic [31:0] iD_Addr,
    input  logic [31:0] iD_WData,
    output logic        oD_Rdy,
    output logic [31:0] oD_RData,
    output logic        oErr,
    output logic        oMem_Req,
    output logic        oMem_Write,
    output logic [31:0] oMem_Addr,
    output logic [31:0] oMem_WData,
    input  logic        iMem_Ack,
    input  logic [31:0] iMem_RData
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          last_q;
    logic          err_q;
    logic          write_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   f_rdata_q;
    logic [31:0]   d_rdata_q;

    logic any_req;
    logic pick_d;

    // D wins alone, or on a tie when F was granted last
    assign any_req = iF_Req | iD_Req;
    assign pick_d  = iD_Req & (~iF_Req | (last_q == REQ_F));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (iMem_Ack || (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            owner_q   <= REQ_F;
            last_q    <= REQ_D;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= pick_d;
                        last_q  <= pick_d;
                        addr_q  <= pick_d ? iD_Addr : iF_Addr;
                        write_q <= pick_d & iD_Write;
                        wdata_q <= pick_d ? iD_WData : '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (iMem_Ack) begin
                        err_q <= 1'b0;
                        if (!write_q) begin
                            if (owner_q == REQ_D) begin
                                d_rdata_q <= iMem_RData;
                            end else begin
                                f_rdata_q <= iMem_RData;
                            end
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        oMem_Req   = (state_q == BUSY);
        oMem_Write = (state_q == BUSY) & write_q;
        oF_Rdy     = (state_q == DONE) & (owner_q == REQ_F);
        oD_Rdy     = (state_q == DONE) & (owner_q == REQ_D);
        oErr       = (state_q == DONE) & err_q;
    end

    assign oMem_Addr  = addr_q;
    assign oMem_WData = wdata_q;
    assign oF_RData   = f_rdata_q;
    assign oD_RData   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a small TIMEOUT.
// Directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iF_Req;
    logic [31:0] iF_Addr;
    logic        oF_Rdy;
    logic [31:0] oF_RData;
    logic        iD_Req;
    logic        iD_Write;
    logic [31:0] iD_Addr;
    logic [31:0] iD_WData;
    logic        oD_Rdy;
    logic [31:0] oD_RData;
    logic        oErr;
    logic        oMem_Req;
    logic        oMem_Write;
    logic [31:0] oMem_Addr;
    logic [31:0] oMem_WData;
    logic        iMem_Ack;
    logic [31:0] iMem_RData;

    int errors = 0;
    int checks = 0;

    logic [31:0] f_rd;
    logic [31:0] d_rd;

    mem_arbiter #(.TIMEOUT(T)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iF_Req     (iF_Req),
        .iF_Addr    (iF_Addr),
        .oF_Rdy     (oF_Rdy),
        .oF_RData   (oF_RData),
        .iD_Req     (iD_Req),
        .iD_Write   (iD_Write),
        .iD_Addr    (iD_Addr),
        .iD_WData   (iD_WData),
        .oD_Rdy     (oD_Rdy),
        .oD_RData   (oD_RData),
        .oErr       (oErr),
        .oMem_Req   (oMem_Req),
        .oMem_Write (oMem_Write),
        .oMem_Addr  (oMem_Addr),
        .oMem_WData (oMem_WData),
        .iMem_Ack   (iMem_Ack),
        .iMem_RData (iMem_RData)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        f_rd = '0;
        d_rd = '0;
    endtask

    // Drives one transaction; bus acks after w wait cycles (w >= T: never).
    task automatic txn(
        input  bit fr, input bit dr, input bit dw,
        input  logic [31:0] fa, input logic [31:0] da,
        input  logic [31:0] wd, input logic [31:0] rd,
        input  int w, input bit chg,
        output bit req1, output logic [31:0] a1,
        output logic [31:0] a_last, output int wcyc,
        output int rcyc, output bit f_o, output bit d_o,
        output bit e_o
    );
        iF_Req = fr; iD_Req = dr; iD_Write = dw;
        iF_Addr = fa; iD_Addr = da; iD_WData = wd;
        tick();
        req1 = oMem_Req; a1 = oMem_Addr; a_last = oMem_Addr;
        wcyc = 0; rcyc = 0; f_o = 0; d_o = 0; e_o = 0;
        for (int c = 1; c <= T + 3; c++) begin
            if (oMem_Req) begin
                wcyc += int'(oMem_Write);
                a_last = oMem_Addr;
            end
            iMem_Ack = oMem_Req && (c - 1 == w);
            iMem_RData = rd;
            if (chg) begin
                iF_Addr = $urandom; iD_Addr = $urandom;
                iD_WData = $urandom; iD_Write = ~iD_Write;
            end
            tick();
            if (oF_Rdy || oD_Rdy) begin
                rcyc = c + 1; f_o = oF_Rdy; d_o = oD_Rdy; e_o = oErr;
                break;
            end
        end
        iMem_Ack = 0; iF_Req = 0; iD_Req = 0; iD_Write = 0;
        tick();
    endtask

    bit r1, fo, dO, eo;
    logic [31:0] a1, al;
    int wc, rc;

    task automatic test_reset();
        iRst = 1'b1;
        tick();
        tick();
        iRst = 1'b0;
        f_rd = '0; d_rd = '0;
        checks++;
        if ({oMem_Req, oMem_Write, oF_Rdy, oD_Rdy, oErr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000",
                {oMem_Req, oMem_Write, oF_Rdy, oD_Rdy, oErr});
        end
        checks++;
        if ({oMem_Addr, oMem_WData, oF_RData, oD_RData} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data got=%h %h %h %h want=0",
                oMem_Addr, oMem_WData, oF_RData, oD_RData);
        end
    endtask

    task automatic test_fetch();
        txn(1, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0,
            r1, a1, al, wc, rc, fo, dO, eo);
        f_rd = 32'hDEADBEEF;
        checks++;
        if (r1 !== 1'b1 || a1 !== 32'h100) begin
            errors++;
            $display("FAIL fetch_bus got req=%b addr=%h want 1 100", r1, a1);
        end
        checks++;
        if (rc !== 2 || fo !== 1 || dO !== 0 || eo !== 0) begin
            errors++;
            $display("FAIL fetch_rdy got cyc=%0d f=%b d=%b e=%b want 2 1 0 0",
                rc, fo, dO, eo);
        end
        checks++;
        if (oF_RData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_data got=%h want=deadbeef", oF_RData);
        end
    endtask

    task automatic test_store();
        txn(0, 1, 1, 0, 32'h2000, 32'h12345678, 32'hCAFEF00D, 3, 0,
            r1, a1, al, wc, rc, fo, dO, eo);
        checks++;
        if (wc !== 4 || a1 !== 32'h2000 || oMem_WData !== 32'h12345678) begin
            errors++;
            $display("FAIL store_bus got wr=%0d addr=%h wd=%h want 4 2000 12345678",
                wc, a1, oMem_WData);
        end
        checks++;
        if (rc !== 5 || dO !== 1 || fo !== 0 || eo !== 0) begin
            errors++;
            $display("FAIL store_rdy got cyc=%0d d=%b f=%b e=%b want 5 1 0 0",
                rc, dO, fo, eo);
        end
        checks++;
        if (oD_RData !== d_rd) begin
            errors++;
            $display("FAIL store_rdata got=%h want=%h", oD_RData, d_rd);
        end
    endtask

    task automatic test_tie();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 32'h1000 + i, 32'h3000 + i, 0, 32'h55 + i, 1, 0,
                r1, a1, al, wc, rc, fo, dO, eo);
            want = (i % 2 == 0) ? 32'h1000 + i : 32'h3000 + i;
            checks++;
            if (a1 !== want || fo !== (i % 2 == 0) || dO !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL tie_%0d got addr=%h f=%b d=%b want addr=%h",
                    i, a1, fo, dO, want);
            end
        end
        f_rd = 32'h55 + 2;
        d_rd = 32'h55 + 3;
    endtask

    task automatic test_timeout();
        txn(0, 1, 0, 0, 32'h44, 0, 32'hBAD0BAD0, T, 0,
            r1, a1, al, wc, rc, fo, dO, eo);
        checks++;
        if (rc !== T + 1 || dO !== 1 || eo !== 1 || oD_RData !== d_rd) begin
            errors++;
            $display("FAIL timeout got cyc=%0d d=%b e=%b rd=%h want %0d 1 1 %h",
                rc, dO, eo, oD_RData, T + 1, d_rd);
        end
        txn(0, 1, 0, 0, 32'h48, 0, 32'h0BADF00D, T - 1, 0,
            r1, a1, al, wc, rc, fo, dO, eo);
        d_rd = 32'h0BADF00D;
        checks++;
        if (rc !== T + 1 || dO !== 1 || eo !== 0 || oD_RData !== d_rd) begin
            errors++;
            $display("FAIL late_ack got cyc=%0d d=%b e=%b rd=%h want %0d 1 0 %h",
                rc, dO, eo, oD_RData, T + 1, d_rd);
        end
    endtask

    task automatic test_reset_busy();
        bit seen;
        iD_Req = 1; iD_Addr = 32'h40; iD_Write = 0;
        tick();
        checks++;
        if (oMem_Req !== 1'b1) begin
            errors++;
            $display("FAIL rb_busy got req=%b want 1", oMem_Req);
        end
        iRst = 1; iD_Req = 0;
        tick();
        iRst = 0;
        f_rd = '0; d_rd = '0;
        seen = oF_Rdy | oD_Rdy;
        checks++;
        if (oMem_Req !== 1'b0) begin
            errors++;
            $display("FAIL rb_req got req=%b want 0", oMem_Req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= oF_Rdy | oD_Rdy | oMem_Req;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rb_quiet got activity=%b want 0", seen);
        end
        txn(1, 0, 0, 32'h300, 0, 0, 32'h600DCAFE, 1, 0,
            r1, a1, al, wc, rc, fo, dO, eo);
        f_rd = 32'h600DCAFE;
        checks++;
        if (rc !== 3 || fo !== 1 || eo !== 0 || oF_RData !== f_rd) begin
            errors++;
            $display("FAIL rb_after got cyc=%0d f=%b e=%b rd=%h want 3 1 0 %h",
                rc, fo, eo, oF_RData, f_rd);
        end
    endtask

    task automatic test_addr_change();
        txn(1, 0, 0, 32'h7700, 0, 0, 32'h13579BDF, 2, 1,
            r1, a1, al, wc, rc, fo, dO, eo);
        f_rd = 32'h13579BDF;
        checks++;
        if (a1 !== 32'h7700 || al !== 32'h7700 || wc !== 0 || rc !== 4) begin
            errors++;
            $display("FAIL addr_hold got a1=%h al=%h wr=%0d cyc=%0d want 7700 7700 0 4",
                a1, al, wc, rc);
        end
    endtask

    task automatic test_random();
        bit last_d, fr, dr, dw, win_d, xe;
        int w, xr, xw;
        logic [31:0] fa, da, wd, rd, xa;
        do_reset();
        last_d = 1;
        for (int i = 0; i < 40; i++) begin
            fr = 1'($urandom); dr = 1'($urandom);
            if (!fr && !dr) dr = 1;
            dw = 1'($urandom);
            fa = $urandom; da = $urandom; wd = $urandom; rd = $urandom;
            w = $urandom_range(0, T);
            win_d = (fr && dr) ? !last_d : dr;
            last_d = win_d;
            xa = win_d ? da : fa;
            xe = (w >= T);
            xr = xe ? T + 1 : w + 2;
            xw = (win_d && dw) ? (xe ? T : w + 1) : 0;
            if (!xe && !(win_d && dw)) begin
                if (win_d) d_rd = rd;
                else f_rd = rd;
            end
            txn(fr, dr, dw, fa, da, wd, rd, w, 0,
                r1, a1, al, wc, rc, fo, dO, eo);
            checks++;
            if (a1 !== xa || wc !== xw || rc !== xr || dO !== win_d ||
                fo !== !win_d || eo !== xe) begin
                errors++;
                $display("FAIL rand_%0d_txn got a=%h wr=%0d cyc=%0d d=%b e=%b want a=%h wr=%0d cyc=%0d d=%b e=%b",
                    i, a1, wc, rc, dO, eo, xa, xw, xr, win_d, xe);
            end
            checks++;
            if (oF_RData !== f_rd || oD_RData !== d_rd) begin
                errors++;
                $display("FAIL rand_%0d_data got f=%h d=%h want f=%h d=%h",
                    i, oF_RData, oD_RData, f_rd, d_rd);
            end
        end
    endtask

    initial begin
        iRst = 1; iF_Req = 0; iF_Addr = 0; iD_Req = 0; iD_Write = 0;
        iD_Addr = 0; iD_WData = 0; iMem_Ack = 0; iMem_RData = 0;
        f_rd = 0; d_rd = 0;
        #1;
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_timeout();
        test_reset_busy();
        test_addr_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
